// File: rtl/mem_rd_arbiter_if.sv
// Purpose : bundles the requester-side (I/D cache) and bus-side (AR/R) signals of the read arbiter.
// Ports   : master = arbiter view (drives gnt/r* to caches, m_ar*/m_rready to bus); slave = environment view.
// Note    : m_arid is 0 for I-cache, 1 for D-cache; busy reflects arbiter state != IDLE.
interface mem_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    // requester side
    logic              i_req,      d_req;
    logic [ADDR_W-1:0] i_addr,     d_addr;
    logic [LEN_W-1:0]  i_len,      d_len;
    logic              i_uncached, d_uncached;
    logic              i_cancel;
    logic              i_gnt,      d_gnt;
    logic              i_rvalid,   d_rvalid;
    logic [DATA_W-1:0] i_rdata,    d_rdata;
    logic              i_rlast,    d_rlast;
    // bus side
    logic              m_arvalid;
    logic [ADDR_W-1:0] m_araddr;
    logic [LEN_W-1:0]  m_arlen;
    logic [3:0]        m_arid;
    logic              m_uncached;
    logic              m_arready;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rlast;
    logic              m_rready;
    logic              busy;

    modport master (
        input  i_req, d_req, i_addr, d_addr, i_len, d_len, i_uncached, d_uncached, i_cancel,
        output i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata, i_rlast, d_rlast,
        output m_arvalid, m_araddr, m_arlen, m_arid, m_uncached, m_rready, busy,
        input  m_arready, m_rvalid, m_rdata, m_rlast
    );

    modport slave (
        output i_req, d_req, i_addr, d_addr, i_len, d_len, i_uncached, d_uncached, i_cancel,
        input  i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata, i_rlast, d_rlast,
        input  m_arvalid, m_araddr, m_arlen, m_arid, m_uncached, m_rready, busy,
        output m_arready, m_rvalid, m_rdata, m_rlast
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Purpose : shares one AXI-like read channel between I-cache and D-cache, one transaction at a time;
//           D has fixed priority, I is guaranteed a win after STARVE_MAX consecutive D wins.
// Ports   : clk, rst_n (async active-low), bus (mem_rd_arbiter_if.master). Request->AR 1 cycle, R path 0 cycles.
module mem_rd_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_rd_arbiter_if.master  bus
);
    localparam int              SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic            OWN_I      = 1'b0;
    localparam logic            OWN_D      = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t            state_q,  state_d;
    logic              owner_q,  owner_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [LEN_W-1:0]  len_q,    len_d;
    logic              unc_q,    unc_d;
    logic              drop_q,   drop_d;
    logic [SC_W-1:0]   starve_q, starve_d;

    logic i_win;
    logic drop_now;
    logic arvalid, rready, i_gnt, d_gnt, i_rv, d_rv;

    // I wins only when D is absent or the starvation guard has tripped.
    assign i_win    = bus.i_req && (!bus.d_req || (starve_q == STARVE_LIM));
    // A cancel arriving this cycle already suppresses this cycle's gnt/beat.
    assign drop_now = drop_q || ((owner_q == OWN_I) && bus.i_cancel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            unc_q    <= 1'b0;
            drop_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            unc_q    <= unc_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        len_d    = len_q;
        unc_d    = unc_q;
        drop_d   = drop_q;
        starve_d = starve_q;
        arvalid  = 1'b0;
        rready   = 1'b0;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rv     = 1'b0;
        d_rv     = 1'b0;
        case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (i_win) begin
                    state_d  = S_ADDR;
                    owner_d  = OWN_I;
                    addr_d   = bus.i_addr;
                    len_d    = bus.i_len;
                    unc_d    = bus.i_uncached;
                    starve_d = '0;
                end else if (bus.d_req) begin
                    state_d = S_ADDR;
                    owner_d = OWN_D;
                    addr_d  = bus.d_addr;
                    len_d   = bus.d_len;
                    unc_d   = bus.d_uncached;
                    // Count only D wins that actually made I wait.
                    if (bus.i_req) begin
                        if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
                    end else begin
                        starve_d = '0;
                    end
                end else begin
                    starve_d = '0;
                end
            end
            S_ADDR: begin
                arvalid = 1'b1;
                drop_d  = drop_now;
                if (bus.m_arready) begin
                    state_d = S_DATA;
                    d_gnt   = (owner_q == OWN_D);
                    i_gnt   = (owner_q == OWN_I) && !drop_now;
                end
            end
            S_DATA: begin
                rready = 1'b1;
                drop_d = drop_now;
                if (bus.m_rvalid) begin
                    d_rv = (owner_q == OWN_D);
                    i_rv = (owner_q == OWN_I) && !drop_now;
                    if (bus.m_rlast) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.m_arvalid  = arvalid;
    assign bus.m_araddr   = addr_q;
    assign bus.m_arlen    = len_q;
    assign bus.m_arid     = {3'b000, owner_q};
    assign bus.m_uncached = unc_q;
    assign bus.m_rready   = rready;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.i_gnt      = i_gnt;
    assign bus.d_gnt      = d_gnt;
    assign bus.i_rvalid   = i_rv;
    assign bus.d_rvalid   = d_rv;
    // Data and last are gated so idle outputs read as zero.
    assign bus.i_rdata    = i_rv ? bus.m_rdata : '0;
    assign bus.d_rdata    = d_rv ? bus.m_rdata : '0;
    assign bus.i_rlast    = i_rv && bus.m_rlast;
    assign bus.d_rlast    = d_rv && bus.m_rlast;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Purpose : directed self-checking bench for mem_rd_arbiter (reset, contention, stall, cancel, async reset).
// Ports   : none; instantiates mem_rd_arbiter_if and the DUT, drives inputs at negedge, samples 1ns later.
// Note    : expected values are hand-derived constants per scenario.
module tb_mem_rd_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_rd_arbiter_if bif ();

    mem_rd_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    // Wait (bounded) for m_arvalid; returns at negedge+1ns of the first ADDR cycle.
    task automatic wait_ar(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (bif.m_arvalid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Present one R beat for one cycle (address handshake input dropped).
    task automatic beat(input logic [31:0] dat, input logic last, input logic cancel);
        @(negedge clk);
        bif.m_arready = 1'b0;
        bif.m_rvalid  = 1'b1;
        bif.m_rdata   = dat;
        bif.m_rlast   = last;
        bif.i_cancel  = cancel;
        #1;
    endtask

    task automatic end_beats();
        @(negedge clk);
        bif.m_rvalid = 1'b0;
        bif.m_rlast  = 1'b0;
        bif.i_cancel = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] ctl;
        bif.i_req = 1'b1; bif.d_req = 1'b1;
        bif.i_addr = 32'h1c00_0000; bif.d_addr = 32'h1c00_0040;
        bif.i_len = 8'd1; bif.d_len = 8'd3;
        bif.i_uncached = 1'b0; bif.d_uncached = 1'b0; bif.i_cancel = 1'b0;
        bif.m_arready = 1'b1; bif.m_rvalid = 1'b1; bif.m_rdata = 32'hffff_ffff; bif.m_rlast = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        ctl = {bif.m_arvalid, bif.m_rready, bif.i_gnt, bif.d_gnt, bif.i_rvalid,
               bif.d_rvalid, bif.busy, bif.m_uncached, bif.i_rlast, bif.d_rlast};
        n_cmp++; if (ctl !== 10'd0) begin n_err++; $display("FAIL rst_ctl: got %b want 0", ctl); end
        n_cmp++; if ({bif.i_rdata, bif.d_rdata} !== 64'd0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", {bif.i_rdata, bif.d_rdata}); end
        n_cmp++; if ({bif.m_araddr, bif.m_arlen, bif.m_arid} !== 44'd0) begin n_err++; $display("FAIL rst_ar: got %h want 0", {bif.m_araddr, bif.m_arlen, bif.m_arid}); end
        // release with only D requesting
        @(negedge clk);
        bif.i_req = 1'b0; bif.m_arready = 1'b0; bif.m_rvalid = 1'b0; bif.m_rlast = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (bif.m_arvalid !== 1'b1) begin n_err++; $display("FAIL rst_ar_next: got %b want 1", bif.m_arvalid); end
        n_cmp++; if (bif.m_arid !== 4'd1) begin n_err++; $display("FAIL rst_arid: got %0d want 1", bif.m_arid); end
        n_cmp++; if (bif.m_arlen !== 8'd3) begin n_err++; $display("FAIL rst_arlen: got %0d want 3", bif.m_arlen); end
        n_cmp++; if (bif.m_araddr !== 32'h1c00_0040) begin n_err++; $display("FAIL rst_araddr: got %h want 1c000040", bif.m_araddr); end
        bif.m_arready = 1'b1; #1;
        n_cmp++; if ({bif.d_gnt, bif.i_gnt} !== 2'b10) begin n_err++; $display("FAIL rst_gnt: got %b want 10", {bif.d_gnt, bif.i_gnt}); end
        for (int k = 0; k < 4; k++) begin
            beat(32'hd000_0000 + k, (k == 3), 1'b0);
            bif.d_req = 1'b0;
            n_cmp++;
            if ({bif.d_rvalid, bif.i_rvalid, bif.m_rready, bif.d_rlast, bif.d_rdata} !== {3'b101, (k == 3), 32'hd000_0000 + k}) begin
                n_err++;
                $display("FAIL rst_beat%0d: got v%b i%b rr%b l%b %h", k, bif.d_rvalid, bif.i_rvalid, bif.m_rready, bif.d_rlast, bif.d_rdata);
            end
        end
        end_beats();
        n_cmp++; if (bif.busy !== 1'b0) begin n_err++; $display("FAIL rst_done_busy: got %b want 0", bif.busy); end
    endtask

    task automatic test_contention();
        bit   seen;
        logic exp_d;
        bif.i_req = 1'b1; bif.d_req = 1'b1;
        bif.i_len = 8'd0; bif.d_len = 8'd0;
        bif.i_addr = 32'h1c00_1000; bif.d_addr = 32'h1c00_2000;
        for (int t = 0; t < 10; t++) begin
            exp_d = ((t % 5) != 4);
            wait_ar(seen);
            n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL cont_ar_timeout%0d: got none want m_arvalid", t); end
            n_cmp++; if (bif.m_arid !== {3'b000, exp_d}) begin n_err++; $display("FAIL cont_arid%0d: got %0d want %0d", t, bif.m_arid, exp_d); end
            n_cmp++; if (bif.m_araddr !== (exp_d ? 32'h1c00_2000 : 32'h1c00_1000)) begin n_err++; $display("FAIL cont_addr%0d: got %h", t, bif.m_araddr); end
            bif.m_arready = 1'b1; #1;
            n_cmp++; if ({bif.d_gnt, bif.i_gnt} !== {exp_d, !exp_d}) begin n_err++; $display("FAIL cont_gnt%0d: got %b want %b", t, {bif.d_gnt, bif.i_gnt}, {exp_d, !exp_d}); end
            beat(32'hc000_0000 + t, 1'b1, 1'b0);
            n_cmp++; if ({bif.d_rvalid, bif.i_rvalid} !== {exp_d, !exp_d}) begin n_err++; $display("FAIL cont_rv%0d: got %b want %b", t, {bif.d_rvalid, bif.i_rvalid}, {exp_d, !exp_d}); end
            end_beats();
            if (t == 9) begin bif.i_req = 1'b0; bif.d_req = 1'b0; end
            n_cmp++; if (bif.m_arvalid !== 1'b0) begin n_err++; $display("FAIL cont_idle_gap%0d: got %b want 0", t, bif.m_arvalid); end
        end
    endtask

    task automatic test_addr_stall();
        bit seen;
        int gnts;
        gnts = 0;
        bif.i_req = 1'b1; bif.i_addr = 32'h1c00_0000; bif.i_len = 8'd2; bif.i_uncached = 1'b1;
        wait_ar(seen);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL stall_ar_timeout: got none want m_arvalid"); end
        n_cmp++; if (bif.m_uncached !== 1'b1) begin n_err++; $display("FAIL stall_uncached: got %b want 1", bif.m_uncached); end
        for (int k = 0; k < 5; k++) begin
            if (k != 0) begin @(negedge clk); #1; end
            gnts += int'(bif.i_gnt);
            n_cmp++;
            if ({bif.m_arvalid, bif.m_araddr, bif.m_arlen} !== {1'b1, 32'h1c00_0000, 8'd2}) begin
                n_err++; $display("FAIL stall_cyc%0d: got v%b %h len %0d", k, bif.m_arvalid, bif.m_araddr, bif.m_arlen);
            end
        end
        @(negedge clk); bif.m_arready = 1'b1; #1;
        gnts += int'(bif.i_gnt);
        n_cmp++; if (bif.i_gnt !== 1'b1) begin n_err++; $display("FAIL stall_gnt_hs: got %b want 1", bif.i_gnt); end
        for (int k = 0; k < 3; k++) begin
            beat(32'ha000_0000 + k, (k == 2), 1'b0);
            bif.i_req = 1'b0; bif.i_uncached = 1'b0;
            gnts += int'(bif.i_gnt);
            n_cmp++; if ({bif.i_rvalid, bif.d_rvalid, bif.i_rdata} !== {2'b10, 32'ha000_0000 + k}) begin n_err++; $display("FAIL stall_beat%0d: got %b%b %h", k, bif.i_rvalid, bif.d_rvalid, bif.i_rdata); end
        end
        end_beats();
        n_cmp++; if (gnts !== 1) begin n_err++; $display("FAIL stall_gnt_count: got %0d want 1", gnts); end
    endtask

    task automatic test_cancel_data();
        bit seen;
        int n_rv;
        n_rv = 0;
        bif.i_req = 1'b1; bif.i_addr = 32'h1c00_0200; bif.i_len = 8'd7;
        wait_ar(seen);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL cdat_ar_timeout: got none want m_arvalid"); end
        bif.m_arready = 1'b1; #1;
        n_cmp++; if (bif.i_gnt !== 1'b1) begin n_err++; $display("FAIL cdat_gnt: got %b want 1", bif.i_gnt); end
        for (int b = 1; b <= 8; b++) begin
            beat(32'hb000_0000 + b, (b == 8), (b == 3));
            bif.i_req = 1'b0;
            n_rv += int'(bif.i_rvalid);
            n_cmp++;
            if ({bif.i_rvalid, bif.m_rready, bif.d_rvalid} !== {(b < 3), 2'b10}) begin
                n_err++; $display("FAIL cdat_beat%0d: got rv%b rr%b d%b want rv%b rr1 d0", b, bif.i_rvalid, bif.m_rready, bif.d_rvalid, (b < 3));
            end
        end
        end_beats();
        n_cmp++; if (n_rv !== 2) begin n_err++; $display("FAIL cdat_rv_count: got %0d want 2", n_rv); end
        n_cmp++; if (bif.busy !== 1'b0) begin n_err++; $display("FAIL cdat_busy: got %b want 0", bif.busy); end
    endtask

    task automatic test_cancel_addr();
        bit seen;
        bif.i_req = 1'b1; bif.i_addr = 32'h1c00_0300; bif.i_len = 8'd1;
        wait_ar(seen);
        n_cmp++; if ((seen !== 1'b1) || (bif.m_arid !== 4'd0)) begin n_err++; $display("FAIL cadr_ar: got seen %b id %0d want 1/0", seen, bif.m_arid); end
        bif.d_req = 1'b1; bif.d_addr = 32'h1c00_0100; bif.d_len = 8'd0;
        bif.i_cancel = 1'b1;
        @(negedge clk);
        bif.i_cancel = 1'b0; bif.m_arready = 1'b1; #1;
        n_cmp++; if ({bif.m_arvalid, bif.i_gnt, bif.d_gnt} !== 3'b100) begin n_err++; $display("FAIL cadr_hs: got %b want 100", {bif.m_arvalid, bif.i_gnt, bif.d_gnt}); end
        for (int k = 0; k < 2; k++) begin
            beat(32'he000_0000 + k, (k == 1), 1'b0);
            bif.i_req = 1'b0;
            n_cmp++; if ({bif.i_rvalid, bif.d_rvalid, bif.m_rready} !== 3'b001) begin n_err++; $display("FAIL cadr_beat%0d: got %b want 001", k, {bif.i_rvalid, bif.d_rvalid, bif.m_rready}); end
        end
        end_beats();
        wait_ar(seen);
        n_cmp++; if ((seen !== 1'b1) || (bif.m_arid !== 4'd1) || (bif.m_araddr !== 32'h1c00_0100)) begin
            n_err++; $display("FAIL cadr_next_d: got seen %b id %0d addr %h want 1/1/1c000100", seen, bif.m_arid, bif.m_araddr);
        end
        bif.m_arready = 1'b1; #1;
        n_cmp++; if (bif.d_gnt !== 1'b1) begin n_err++; $display("FAIL cadr_dgnt: got %b want 1", bif.d_gnt); end
        beat(32'h1234_5678, 1'b1, 1'b0);
        bif.d_req = 1'b0;
        n_cmp++; if ({bif.d_rvalid, bif.d_rdata} !== {1'b1, 32'h1234_5678}) begin n_err++; $display("FAIL cadr_dbeat: got %b %h", bif.d_rvalid, bif.d_rdata); end
        end_beats();
    endtask

    task automatic test_reset_mid_burst();
        bit seen;
        bif.d_req = 1'b1; bif.d_addr = 32'h1c00_0400; bif.d_len = 8'd3;
        wait_ar(seen);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rmid_ar_timeout: got none want m_arvalid"); end
        bif.m_arready = 1'b1;
        beat(32'hf000_0001, 1'b0, 1'b0);
        bif.d_req = 1'b0;
        beat(32'hf000_0002, 1'b0, 1'b0);
        n_cmp++; if (bif.d_rvalid !== 1'b1) begin n_err++; $display("FAIL rmid_beat2: got %b want 1", bif.d_rvalid); end
        rst_n = 1'b0; #1;
        n_cmp++; if ({bif.d_rvalid, bif.busy, bif.m_rready, bif.d_rdata} !== 35'd0) begin
            n_err++; $display("FAIL rmid_async: got rv%b busy%b rr%b %h want 0", bif.d_rvalid, bif.busy, bif.m_rready, bif.d_rdata);
        end
        @(negedge clk);
        bif.m_rvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if ({bif.busy, bif.m_arvalid} !== 2'b00) begin n_err++; $display("FAIL rmid_idle: got %b want 00", {bif.busy, bif.m_arvalid}); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_addr_stall();
        test_cancel_data();
        test_cancel_addr();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
